// File: rtl/ptxuart_if.sv
// Producer-side handshake of the UART transmitter: write/break requests in,
// busy back-pressure out.
interface ptxuart_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_break;
  logic       o_busy;

  modport master (
    output i_wr,
    output i_data,
    output i_break,
    input  o_busy
  );

  modport slave (
    input  i_wr,
    input  i_data,
    input  i_break,
    output o_busy
  );
endinterface

// File: rtl/ptxuart.sv
// Parametrised UART transmitter: start, NDATA data bits LSB first, optional
// parity, NSTOP stop bits, plus a line-break generator with one-bit recovery.
module ptxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          NDATA           = 8,
  parameter logic [1:0]  PARITY          = 2'b00,
  parameter int          NSTOP           = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  ptxuart_if.slave      bus,
  output logic          o_uart_tx,
  output logic [7:0]    o_dbg_data,
  output logic [31:0]   o_dbg_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BRKREC
  } state_t;

  localparam logic [23:0] CPB_M1    = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [2:0]  LAST_DATA = 3'(NDATA - 1);
  localparam logic [2:0]  LAST_STOP = 3'(NSTOP - 1);

  logic [1:0]  rst_sync_reg;
  logic        rst_n_int;

  state_t      state_reg, state_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        par_reg, par_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic [7:0]  dbg_data_reg, dbg_data_next;
  logic [31:0] dbg_count_reg, dbg_count_next;

  logic [7:0]  data_masked;
  logic        data_par;
  logic        strobe;

  // Assertion reaches the FSM immediately; deassertion is retimed to i_clk.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi < NDATA) begin : g_keep
        assign data_masked[gi] = bus.i_data[gi];
      end else begin : g_zero
        assign data_masked[gi] = 1'b0;
      end
    end
  endgenerate

  assign data_par = (PARITY == 2'b01) ? ~(^data_masked) : ^data_masked;
  assign strobe   = (cnt_reg == 24'd0);

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 24'd0;
      idx_reg       <= 3'd0;
      shift_reg     <= 8'd0;
      par_reg       <= 1'b0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      dbg_data_reg  <= 8'd0;
      dbg_count_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      par_reg       <= par_next;
      tx_reg        <= tx_next;
      busy_reg      <= busy_next;
      dbg_data_reg  <= dbg_data_next;
      dbg_count_reg <= dbg_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = strobe ? cnt_reg : cnt_reg - 24'd1;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    par_next       = par_reg;
    dbg_data_next  = dbg_data_reg;
    dbg_count_next = (busy_reg && (dbg_count_reg != '1)) ? dbg_count_reg + 32'd1
                                                         : dbg_count_reg;

    case (state_reg)
      S_START: if (strobe) begin
        state_next = S_DATA;
        idx_next   = 3'd0;
        cnt_next   = CPB_M1;
      end
      S_DATA: if (strobe) begin
        cnt_next   = CPB_M1;
        shift_next = {1'b0, shift_reg[7:1]};
        if (idx_reg == LAST_DATA) begin
          state_next = (PARITY != 2'b00) ? S_PARITY : S_STOP;
          idx_next   = 3'd0;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      S_PARITY: if (strobe) begin
        state_next = S_STOP;
        idx_next   = 3'd0;
        cnt_next   = CPB_M1;
      end
      S_STOP: if (strobe) begin
        if (idx_reg == LAST_STOP) begin
          state_next = S_IDLE;
        end else begin
          idx_next = idx_reg + 3'd1;
          cnt_next = CPB_M1;
        end
      end
      S_BREAK: if (!bus.i_break) begin
        state_next = S_BRKREC;
        cnt_next   = CPB_M1;
      end
      S_BRKREC: if (strobe) state_next = S_IDLE;
      default: ;
    endcase

    // Not busy means idle or the final stop cycle, so a new frame or a break
    // can start on this edge with no gap; break wins over a pending write.
    if (!busy_reg) begin
      if (bus.i_break) begin
        state_next = S_BREAK;
        cnt_next   = 24'd0;
      end else if (bus.i_wr) begin
        state_next     = S_START;
        cnt_next       = CPB_M1;
        idx_next       = 3'd0;
        shift_next     = data_masked;
        par_next       = data_par;
        dbg_data_next  = bus.i_data;
        dbg_count_next = 32'd0;
      end
    end

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_next;
      S_BREAK:  tx_next = 1'b0;
      default:  tx_next = 1'b1;
    endcase

    case (state_next)
      S_IDLE:  busy_next = 1'b0;
      S_STOP:  busy_next = !((idx_next == LAST_STOP) && (cnt_next == 24'd0));
      default: busy_next = 1'b1;
    endcase
  end

  assign o_uart_tx   = tx_reg;
  assign bus.o_busy  = busy_reg;
  assign o_dbg_data  = dbg_data_reg;
  assign o_dbg_count = dbg_count_reg;

endmodule

// File: tb/tb_ptxuart.sv
// Directed bench for ptxuart: four configurations checked cycle by cycle
// against hand-computed frame bit patterns.
module tb_ptxuart;
  logic clk = 1'b0;
  logic rst_n;
  int   tests;
  int   fails;
  int   sel;

  logic        tx0, tx1, tx2, tx3;
  logic [7:0]  dd0, dd1, dd2, dd3;
  logic [31:0] dc0, dc1, dc2, dc3;

  logic        obs_tx, obs_busy;
  logic [7:0]  obs_dat;
  logic [31:0] obs_cnt;

  ptxuart_if if0 ();
  ptxuart_if if1 ();
  ptxuart_if if2 ();
  ptxuart_if if3 ();

  always #5 clk = ~clk;

  ptxuart #(.CLOCKS_PER_BAUD(24'd4), .NDATA(8), .PARITY(2'b00), .NSTOP(1)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if0),
    .o_uart_tx(tx0), .o_dbg_data(dd0), .o_dbg_count(dc0));
  ptxuart #(.CLOCKS_PER_BAUD(24'd4), .NDATA(8), .PARITY(2'b10), .NSTOP(1)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if1),
    .o_uart_tx(tx1), .o_dbg_data(dd1), .o_dbg_count(dc1));
  ptxuart #(.CLOCKS_PER_BAUD(24'd4), .NDATA(8), .PARITY(2'b01), .NSTOP(1)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if2),
    .o_uart_tx(tx2), .o_dbg_data(dd2), .o_dbg_count(dc2));
  ptxuart #(.CLOCKS_PER_BAUD(24'd3), .NDATA(7), .PARITY(2'b00), .NSTOP(2)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if3),
    .o_uart_tx(tx3), .o_dbg_data(dd3), .o_dbg_count(dc3));

  always_comb begin
    obs_tx = tx0; obs_busy = if0.o_busy; obs_dat = dd0; obs_cnt = dc0;
    case (sel)
      1: begin obs_tx = tx1; obs_busy = if1.o_busy; obs_dat = dd1; obs_cnt = dc1; end
      2: begin obs_tx = tx2; obs_busy = if2.o_busy; obs_dat = dd2; obs_cnt = dc2; end
      3: begin obs_tx = tx3; obs_busy = if3.o_busy; obs_dat = dd3; obs_cnt = dc3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic wr, input logic [7:0] d, input logic brk);
    case (s)
      0: begin if0.i_wr = wr; if0.i_data = d; if0.i_break = brk; end
      1: begin if1.i_wr = wr; if1.i_data = d; if1.i_break = brk; end
      2: begin if2.i_wr = wr; if2.i_data = d; if2.i_break = brk; end
      default: begin if3.i_wr = wr; if3.i_data = d; if3.i_break = brk; end
    endcase
  endtask

  // Starts at the sampling point of the first start-bit cycle, ends at the
  // sampling point of the last stop-bit cycle.
  task automatic check_bits(input logic [7:0] d, input logic [11:0] bits,
                            input int n, input int cpb);
    int total;
    total = n * cpb;
    check("dbg_data", {24'd0, obs_dat}, {24'd0, d});
    for (int c = 0; c < total; c++) begin
      check($sformatf("tx c=%0d", c), {31'd0, obs_tx}, {31'd0, bits[c / cpb]});
      check($sformatf("busy c=%0d", c), {31'd0, obs_busy}, {31'd0, (c != total - 1)});
      check($sformatf("dbg_count c=%0d", c), obs_cnt, c);
      if (c < total - 1) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int s, input logic [7:0] d, input logic [11:0] bits,
                           input int n, input int cpb);
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, d, 1'b0);
    @(negedge clk);
    drive(s, 1'b0, d, 1'b0);
    check_bits(d, bits, n, cpb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    sel   = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("reset tx", {31'd0, obs_tx}, 32'd1);
      check("reset busy", {31'd0, obs_busy}, 32'd0);
      check("reset dbg_data", {24'd0, obs_dat}, 32'd0);
      check("reset dbg_count", obs_cnt, 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0x55, 8E1 0x07, 8O1 0x07, 7N2 0xFF and 0x55
    run_frame(0, 8'h55, 12'b0010_1010_1010, 10, 4);
    run_frame(1, 8'h07, 12'b0110_0000_1110, 11, 4);
    run_frame(2, 8'h07, 12'b0100_0000_1110, 11, 4);
    run_frame(3, 8'hFF, 12'b0011_1111_1110, 10, 3);
    run_frame(3, 8'h55, 12'b0011_1010_1010, 10, 3);

    // back-to-back writes with i_wr held
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 8'h3C, 1'b0);
    check_bits(8'hA5, 12'b0011_0100_1010, 10, 4);
    @(negedge clk);
    drive(0, 1'b0, 8'h3C, 1'b0);
    check_bits(8'h3C, 12'b0010_0111_1000, 10, 4);

    // asynchronous reset in the 13th cycle of a frame
    @(negedge clk);
    drive(0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (12) @(negedge clk);
    check("pre-reset tx", {31'd0, obs_tx}, 32'd0);
    check("pre-reset busy", {31'd0, obs_busy}, 32'd1);
    check("pre-reset dbg_count", obs_cnt, 32'd12);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset tx", {31'd0, obs_tx}, 32'd1);
    check("mid-frame reset busy", {31'd0, obs_busy}, 32'd0);
    check("mid-frame reset dbg_data", {24'd0, obs_dat}, 32'd0);
    check("mid-frame reset dbg_count", obs_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-release tx", {31'd0, obs_tx}, 32'd1);
    check("post-release busy", {31'd0, obs_busy}, 32'd0);
    run_frame(0, 8'h3C, 12'b0010_0111_1000, 10, 4);

    // 20-cycle break with a write pending, then recovery and the write
    @(negedge clk);
    drive(0, 1'b1, 8'hA5, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("break tx i=%0d", i), {31'd0, obs_tx}, 32'd0);
      check($sformatf("break busy i=%0d", i), {31'd0, obs_busy}, 32'd1);
      if (i == 1) check("break dbg_data", {24'd0, obs_dat}, 32'h3C);
      if (i == 20) drive(0, 1'b1, 8'hA5, 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("brkrec tx i=%0d", i), {31'd0, obs_tx}, 32'd1);
      check($sformatf("brkrec busy i=%0d", i), {31'd0, obs_busy}, 32'd1);
    end
    @(negedge clk);
    check("post-break idle tx", {31'd0, obs_tx}, 32'd1);
    check("post-break idle busy", {31'd0, obs_busy}, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 8'hA5, 1'b0);
    check_bits(8'hA5, 12'b0011_0100_1010, 10, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
